// File: rtl/aes_dec_loader.sv
// rtl/aes_dec_loader.sv - word-stream loader and result capture for the AES decryption core
//
// Packs a 32-bit key/ciphertext stream into the core's wide inputs, derives
// Nk/Nr, fires a one-cycle core reset to launch a run and captures the result.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   key_size, new_key          job setup, sampled in IDLE when in_valid is high
//   in_word, in_valid, in_ready input word stream (key words, then 4 ct words)
//   core_key, core_nk, core_nr, core_block, core_rst   core launch interface
//   core_done, core_result     core completion (level) and result block
//   out_data, out_valid, out_ready   captured plaintext with handshake
//   err                        sticky error (illegal key size, no key, timeout)
module aes_dec_loader #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   key_size,
    input  logic         new_key,
    input  logic [31:0]  in_word,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] core_key,
    output logic [3:0]   core_nk,
    output logic [3:0]   core_nr,
    output logic [127:0] core_block,
    output logic         core_rst,
    input  logic         core_done,
    input  logic [127:0] core_result,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_DATA,
        S_LAUNCH,
        S_RUN,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    wcnt;
    logic [TW-1:0] tcnt;
    logic          key_ok;

    logic          accept;
    logic          bad_size;
    logic          no_key;
    logic          key_last;
    logic          data_last;
    logic          timeout_hit;
    logic [3:0]    nk_sel;

    // Nk = 4 + 2*key_size for the three legal sizes.
    assign nk_sel = 4'd4 + {1'b0, key_size, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        core_rst    = 1'b0;
        bad_size    = (key_size == 2'd3);
        no_key      = !new_key && !key_ok;
        key_last    = (wcnt == 3'(core_nk - 4'd1));
        data_last   = (wcnt[1:0] == 2'd3);
        timeout_hit = (tcnt == TW'(TIMEOUT - 1));

        case (state)
            S_LOAD_KEY, S_LOAD_DATA: in_ready = 1'b1;
            S_LAUNCH:                core_rst = 1'b1;
            default:                 ;
        endcase
        accept = in_valid && in_ready;

        case (state)
            S_IDLE: begin
                // The triggering word is not consumed; it is taken in LOAD_*.
                if (in_valid && !bad_size && !no_key) begin
                    state_nxt = new_key ? S_LOAD_KEY : S_LOAD_DATA;
                end
            end
            S_LOAD_KEY: begin
                if (accept && key_last) begin
                    state_nxt = S_LOAD_DATA;
                end
            end
            S_LOAD_DATA: begin
                if (accept && data_last) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN: begin
                if (core_done) begin
                    state_nxt = S_OUT;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_key   <= '0;
            core_block <= '0;
            core_nk    <= '0;
            core_nr    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            key_ok     <= 1'b0;
            wcnt       <= '0;
            tcnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (bad_size || no_key) begin
                            err <= 1'b1;
                        end else begin
                            wcnt <= '0;
                            if (new_key) begin
                                core_nk  <= nk_sel;
                                core_nr  <= nk_sel + 4'd6;
                                core_key <= '0;
                            end
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (accept) begin
                        // Word i lands at bit 255-32*i; 7-i equals ~i in 3 bits.
                        core_key[{~wcnt, 5'b00000} +: 32] <= in_word;
                        if (key_last) begin
                            key_ok <= 1'b1;
                            wcnt   <= '0;
                        end else begin
                            wcnt <= wcnt + 3'd1;
                        end
                    end
                end
                S_LOAD_DATA: begin
                    if (accept) begin
                        core_block[{~wcnt[1:0], 5'b00000} +: 32] <= in_word;
                        wcnt <= data_last ? 3'd0 : wcnt + 3'd1;
                    end
                end
                S_LAUNCH: begin
                    tcnt <= '0;
                end
                S_RUN: begin
                    if (core_done) begin
                        out_data  <= core_result;
                        out_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_loader.sv
// tb/tb_aes_dec_loader.sv - scoreboard testbench for aes_dec_loader
module tb_aes_dec_loader;

    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   key_size;
    logic         new_key;
    logic [31:0]  in_word;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] core_key;
    logic [3:0]   core_nk;
    logic [3:0]   core_nr;
    logic [127:0] core_block;
    logic         core_rst;
    logic         core_done;
    logic [127:0] core_result;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    aes_dec_loader #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .key_size(key_size), .new_key(new_key),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .core_key(core_key), .core_nk(core_nk), .core_nr(core_nr),
        .core_block(core_block), .core_rst(core_rst), .core_done(core_done),
        .core_result(core_result), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] key;
        logic [127:0] blk;
        logic [3:0]   nk;
        logic [3:0]   nr;
    } launch_t;

    launch_t      launch_q[$];
    logic [127:0] out_q[$];
    int           total = 0;
    int           bad = 0;
    int           hs = 0;

    logic [31:0]  kw[8];
    logic [31:0]  cw[4];
    logic [255:0] model_key;
    int           model_nk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts input handshakes, checks launches and outputs against the queues.
    initial begin
        launch_t      e;
        logic [127:0] r;
        logic         prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (in_valid && in_ready) hs++;
                if (core_rst) begin
                    check("core_rst single cycle", prev_rst, 1'b0);
                    if (launch_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected launch: got core_rst=1 expected no launch");
                    end else begin
                        e = launch_q.pop_front();
                        check("launch core_key", core_key, e.key);
                        check("launch core_block", core_block, e.blk);
                        check("launch core_nk", core_nk, e.nk);
                        check("launch core_nr", core_nr, e.nr);
                    end
                end
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected output: got %h expected none", out_data);
                    end else begin
                        r = out_q.pop_front();
                        check("out_data at handshake", out_data, r);
                    end
                end
                prev_rst = core_rst;
            end else begin
                prev_rst = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        int  g;
        logic acc;
        g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
        repeat (g) begin
            in_valid = 1'b0; core_done = 1'($urandom); core_result = {4{$urandom}};
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_word = w; acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL word accept: got no in_ready expected accept within 20 cycles");
        end
        in_valid = 1'b0; core_done = 1'b0;
    endtask

    // One job: lat < 0 means the core never finishes.
    task automatic run_job(input logic [1:0] ks, input logic nkey, input int lat,
                           input logic [127:0] res, input int bp, input int gapmax);
        launch_t      e;
        logic [255:0] k;
        int           h0, n, stray;
        h0 = hs;
        if (nkey) begin
            model_nk = 4 + 2 * int'(ks);
            k = '0;
            for (int i = 0; i < model_nk; i++) k = (k << 32) | 256'(kw[i]);
            model_key = k << (32 * (8 - model_nk));
        end
        e.key = model_key;
        e.blk = {cw[0], cw[1], cw[2], cw[3]};
        e.nk  = 4'(model_nk);
        e.nr  = 4'(model_nk + 6);
        launch_q.push_back(e);
        key_size = ks; new_key = nkey;
        n = nkey ? model_nk + 4 : 4;
        if (nkey) for (int i = 0; i < model_nk; i++) send_word(kw[i], gapmax);
        for (int i = 0; i < 4; i++) send_word(cw[i], gapmax);
        core_done = 1'b0;
        @(negedge clk);
        check("core_rst after last word", core_rst, 1'b1);
        check("handshake count", 256'(hs - h0), 256'(n));
        @(posedge clk); #1;
        stray = 0;
        if (lat < 0) begin
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                if (err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) stray++;
                @(posedge clk); #1;
            end
            check("quiet run before timeout", 256'(stray), 256'(0));
            @(negedge clk);
            check("err after timeout", err, 1'b1);
            check("out_valid after timeout", out_valid, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
            check("in_ready idle after timeout", in_ready, 1'b0);
        end else begin
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                if (in_ready !== 1'b0 || out_valid !== 1'b0) stray++;
                @(posedge clk); #1;
            end
            core_result = res; core_done = 1'b1;
            out_q.push_back(res);
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) stray++;
            check("run in_ready/out_valid low", 256'(stray), 256'(0));
            @(posedge clk); #1;
            core_done = 1'b0; core_result = {4{$urandom}};
            @(negedge clk);
            check("out_valid latency", out_valid, 1'b1);
            check("out_data captured", out_data, res);
            check("core_key held", core_key, e.key);
            stray = 0;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== res) stray++;
            end
            check("output held under backpressure", 256'(stray), 256'(0));
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
            @(negedge clk);
            check("out_valid cleared", out_valid, 1'b0);
        end
    endtask

    task automatic bad_start(input logic [1:0] ks, input logic nkey, input string name);
        int h0;
        h0 = hs;
        key_size = ks; new_key = nkey; in_valid = 1'b1; in_word = $urandom;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check({name, " err"}, err, 1'b1);
        check({name, " in_ready"}, in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " no word consumed"}, 256'(hs - h0), 256'(0));
    endtask

    initial begin
        logic [1:0] ks;
        logic       nk;
        key_size = 2'd0; new_key = 1'b0; in_word = '0; in_valid = 1'b0;
        core_done = 1'b0; core_result = '0; out_ready = 1'b0; rst = 1'b1;
        model_key = '0; model_nk = 0;
        do_reset();
        @(negedge clk);
        check("reset in_ready", in_ready, 1'b0);
        check("reset core_rst", core_rst, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset err", err, 1'b0);
        check("reset core_key", core_key, '0);
        check("reset core_block", core_block, '0);
        check("reset out_data", out_data, '0);
        check("reset core_nk", core_nk, '0);
        check("reset core_nr", core_nr, '0);

        bad_start(2'd0, 1'b0, "reuse without key");
        do_reset();
        @(negedge clk);
        check("err cleared by rst", err, 1'b0);
        bad_start(2'd3, 1'b1, "illegal key_size");

        // FIPS-197 C.1 vectors; err already set must not block the job.
        kw[0] = 32'h00010203; kw[1] = 32'h04050607; kw[2] = 32'h08090a0b; kw[3] = 32'h0c0d0e0f;
        cw[0] = 32'h69c4e0d8; cw[1] = 32'h6a7b0430; cw[2] = 32'hd8cdb780; cw[3] = 32'h70b4c55a;
        run_job(2'd0, 1'b1, 3, 128'h00112233445566778899aabbccddeeff, 5, 0);
        check("err sticky across job", err, 1'b1);

        for (int i = 0; i < 8; i++) kw[i] = $urandom;
        for (int i = 0; i < 4; i++) cw[i] = $urandom;
        run_job(2'd2, 1'b1, $urandom_range(8, 0), {4{$urandom}}, 2, 3);

        for (int i = 0; i < 4; i++) cw[i] = $urandom;
        run_job(2'd1, 1'b0, 2, {4{$urandom}}, 1, 2);

        for (int j = 0; j < 8; j++) begin
            ks = 2'($urandom_range(2, 0));
            nk = 1'($urandom);
            for (int i = 0; i < 8; i++) kw[i] = $urandom;
            for (int i = 0; i < 4; i++) cw[i] = $urandom;
            run_job(ks, nk, $urandom_range(15, 0), {4{$urandom}}, $urandom_range(3, 0), 3);
        end

        do_reset();
        for (int i = 0; i < 8; i++) kw[i] = $urandom;
        for (int i = 0; i < 4; i++) cw[i] = $urandom;
        run_job(2'($urandom_range(2, 0)), 1'b1, -1, '0, 0, 1);

        do_reset();
        for (int i = 0; i < 8; i++) kw[i] = $urandom;
        key_size = 2'd2; new_key = 1'b1;
        send_word(kw[0], 0);
        send_word(kw[1], 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid rst in_ready", in_ready, 1'b0);
        check("mid rst core_key", core_key, '0);
        check("mid rst core_nk", core_nk, '0);
        check("mid rst core_nr", core_nr, '0);
        check("mid rst out_valid", out_valid, 1'b0);
        check("mid rst err", err, 1'b0);
        bad_start(2'd0, 1'b0, "key_ok cleared by rst");

        check("launch queue drained", 256'(launch_q.size()), 256'(0));
        check("output queue drained", 256'(out_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
